// File: rtl/mem_wb_stage.sv
// mem_wb_stage: data-memory access stage plus the MEM/WB pipeline register.
// Loads and stores go out over a req/ack handshake; the pipeline is held
// while a request is pending, and an access that never gets an ack is
// abandoned after MAX_WAIT stalled cycles, raising a sticky error flag.
module mem_wb_stage #(
  parameter int MAX_WAIT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        dmem_wen_exmem,
  input  logic        mem2reg_exmem,
  input  logic        nop_sw_exmem,
  input  logic        nop_lw_exmem,
  input  logic        rf_wen_exmem,
  input  logic [3:0]  rf_waddr_exmem,
  input  logic        branch2_exmem,
  input  logic        jal_exmem,
  input  logic [15:0] aluout_exmem,
  input  logic [15:0] rdata2_exmem,
  input  logic [2:0]  flag_exmem,
  input  logic [15:0] branch_target_exmem,
  input  logic [15:0] pc_added_exmem,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [15:0] dmem_addr,
  output logic [15:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [15:0] dmem_rdata,
  output logic        stall_mem,
  output logic        branch_taken,
  output logic [15:0] branch_target_mem,
  output logic        dmem_err,
  output logic        rf_wen_memwb,
  output logic [3:0]  rf_waddr_memwb,
  output logic [15:0] rf_wdata_memwb
);

  localparam logic [7:0] MAX_CNT = 8'(MAX_WAIT);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t      state, state_nxt;
  logic [7:0]  wait_cnt, wait_cnt_nxt;
  logic        load, store, mem_op, timeout;
  logic [15:0] wb_data;

  // Squash bits suppress the access; a store wins over a simultaneous load.
  assign load   = mem2reg_exmem & ~nop_lw_exmem;
  assign store  = dmem_wen_exmem & ~nop_sw_exmem;
  assign mem_op = load | store;

  assign dmem_addr         = aluout_exmem;
  assign dmem_wdata        = rdata2_exmem;
  assign dmem_we           = store & dmem_req;
  assign branch_target_mem = branch_target_exmem;

  // State register and wait counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      wait_cnt <= 8'd0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
    end
  end

  // Next state: enter WAIT on a missed ack, leave on ack or timeout.
  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    case (state)
      IDLE: if (mem_op && !dmem_ack) begin
        state_nxt    = WAIT;
        wait_cnt_nxt = 8'd1;
      end
      WAIT: if (dmem_ack || timeout) begin
        state_nxt    = IDLE;
        wait_cnt_nxt = 8'd0;
      end else if (wait_cnt != 8'hFF) begin
        wait_cnt_nxt = wait_cnt + 8'd1;
      end
      default: begin
        state_nxt    = IDLE;
        wait_cnt_nxt = 8'd0;
      end
    endcase
  end

  // Outputs: request is dropped in the timeout cycle so the stall ends there.
  always_comb begin
    timeout  = 1'b0;
    dmem_req = 1'b0;
    case (state)
      IDLE: dmem_req = mem_op;
      WAIT: begin
        timeout  = !dmem_ack && (wait_cnt == MAX_CNT);
        dmem_req = !timeout;
      end
      default: ;
    endcase
  end

  assign stall_mem    = dmem_req & ~dmem_ack & ~timeout;
  assign branch_taken = branch2_exmem & flag_exmem[0] & ~stall_mem;

  // Write-back select: jal link, then load data (zero if abandoned), then ALU.
  always_comb begin
    wb_data = aluout_exmem;
    if (jal_exmem)           wb_data = pc_added_exmem;
    else if (load && !store) wb_data = timeout ? 16'h0000 : dmem_rdata;
  end

  // Sticky timeout flag; only reset clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       dmem_err <= 1'b0;
    else if (timeout) dmem_err <= 1'b1;
  end

  // MEM/WB register: bubble (write disabled, address/data held) on stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_wen_memwb   <= 1'b0;
      rf_waddr_memwb <= 4'd0;
      rf_wdata_memwb <= 16'h0000;
    end else if (stall_mem) begin
      rf_wen_memwb   <= 1'b0;
    end else begin
      rf_wen_memwb   <= rf_wen_exmem;
      rf_waddr_memwb <= rf_waddr_exmem;
      rf_wdata_memwb <= wb_data;
    end
  end

endmodule
